// File: rtl/systolic_array_ctrl.sv
// Sequencer for a 4x4 systolic array. The phases are CLEAR, LOAD_B, STREAM, DRAIN and DONE, and abort can cancel a job.
// Define SYSTOLIC_ARRAY_CTRL_PERF_CNT_EN to build the busy-cycle and job performance counters.
module systolic_array_ctrl #(
  parameter int STREAM_LEN = 7,
  parameter int DRAIN_LEN  = 13
) (
  input  logic        Clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        data_clear,
  output logic        en_b_shift_bottom,
  output logic        en_shift_right,
  output logic        en_shift_bottom,
  output logic [1:0]  b_row_idx,
  output logic [4:0]  a_step,
  output logic [3:0]  a_row_valid,
  output logic        ps_capture,
  output logic [1:0]  ps_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_busy_cycles,
  output logic [15:0] perf_jobs
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD_B = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5,
    S_ABORT  = 3'd6
  } state_e;

  localparam logic [4:0] STREAM_LAST = 5'(STREAM_LEN - 1);
  localparam logic [4:0] DRAIN_LAST  = 5'(DRAIN_LEN - 1);
  localparam logic [4:0] CAP_FIRST   = 5'(DRAIN_LEN - 4);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       abortable_s;

  // State and phase-counter registers
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. Abort overrides the normal progress of a running job.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR; else state_d = S_IDLE;
      S_CLEAR:  state_d = S_LOAD_B;
      S_LOAD_B: if (cnt_q == 5'd3) state_d = S_STREAM; else state_d = S_LOAD_B;
      S_STREAM: if (cnt_q == STREAM_LAST) state_d = S_DRAIN; else state_d = S_STREAM;
      S_DRAIN:  if (cnt_q == DRAIN_LAST) state_d = S_DONE; else state_d = S_DRAIN;
      S_DONE:   state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    abortable_s = (state_q == S_CLEAR) || (state_q == S_LOAD_B) ||
                  (state_q == S_STREAM) || (state_q == S_DRAIN);
    if (abort && abortable_s) begin
      state_d = S_ABORT;
    end else begin
      state_d = state_d;
    end
    // The counter restarts at 0 on every state change. It saturates, so a long stay in IDLE cannot wrap it.
    if (state_d != state_q) begin
      cnt_d = 5'd0;
    end else if (cnt_q == 5'd31) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  // Moore output decode from the registered state and the phase counter
  always_comb begin
    data_clear        = 1'b0;
    en_b_shift_bottom = 1'b0;
    en_shift_right    = 1'b0;
    en_shift_bottom   = 1'b0;
    b_row_idx         = 2'd0;
    a_step            = 5'd0;
    a_row_valid       = 4'd0;
    ps_capture        = 1'b0;
    ps_idx            = 2'd0;
    busy              = 1'b0;
    done              = 1'b0;
    case (state_q)
      S_CLEAR, S_ABORT: begin
        data_clear = 1'b1;
        busy       = 1'b1;
      end
      S_LOAD_B: begin
        en_b_shift_bottom = 1'b1;
        b_row_idx         = 2'(5'd3 - cnt_q);
        busy              = 1'b1;
      end
      S_STREAM: begin
        en_shift_right  = 1'b1;
        en_shift_bottom = 1'b1;
        a_step          = cnt_q;
        busy            = 1'b1;
        for (int r = 0; r < 4; r++) begin
          a_row_valid[r] = (cnt_q >= 5'(r)) && ((cnt_q - 5'(r)) <= 5'd3);
        end
      end
      S_DRAIN: begin
        en_shift_right  = 1'b1;
        en_shift_bottom = 1'b1;
        busy            = 1'b1;
        if (cnt_q >= CAP_FIRST) begin
          ps_capture = 1'b1;
          ps_idx     = 2'(cnt_q - CAP_FIRST);
        end else begin
          ps_capture = 1'b0;
          ps_idx     = 2'd0;
        end
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

`ifdef SYSTOLIC_ARRAY_CTRL_PERF_CNT_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_jobs_q;

  // The busy-cycle counter saturates at all-ones. The job counter wraps.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q <= 32'd0;
      perf_jobs_q <= 16'd0;
    end else begin
      if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (done) begin
        perf_jobs_q <= perf_jobs_q + 16'd1;
      end
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_jobs        = perf_jobs_q;
`else
  assign perf_busy_cycles = 32'd0;
  assign perf_jobs        = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl. For every cycle the stimulus queues the expected output vector from a hand-written job timeline.
// A separate monitor pops each entry and compares it on the falling edge.
module tb_systolic_array_ctrl;

  logic        Clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom;
  logic [1:0]  b_row_idx;
  logic [4:0]  a_step;
  logic [3:0]  a_row_valid;
  logic        ps_capture;
  logic [1:0]  ps_idx;
  logic        busy, done;
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_jobs;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_s;
  logic [3:0]  arv_tab [0:6];

  localparam logic [19:0] ZERO = 20'd0;

  systolic_array_ctrl dut (
    .Clock(Clock), .rst_n(rst_n), .start(start), .abort(abort),
    .data_clear(data_clear), .en_b_shift_bottom(en_b_shift_bottom),
    .en_shift_right(en_shift_right), .en_shift_bottom(en_shift_bottom),
    .b_row_idx(b_row_idx), .a_step(a_step), .a_row_valid(a_row_valid),
    .ps_capture(ps_capture), .ps_idx(ps_idx), .busy(busy), .done(done),
    .perf_busy_cycles(perf_busy_cycles), .perf_jobs(perf_jobs)
  );

  always #5 Clock = ~Clock;

  assign got_s = {data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom,
                  b_row_idx, a_step, a_row_valid, ps_capture, ps_idx, busy, done};

  function automatic logic [19:0] mk(input logic dc, input logic eb, input logic er, input logic es,
                                     input logic [1:0] bi, input logic [4:0] st, input logic [3:0] arv,
                                     input logic pc, input logic [1:0] pi, input logic bz, input logic dn);
    return {dc, eb, er, es, bi, st, arv, pc, pi, bz, dn};
  endfunction

  // Expected outputs in cycle k of a default job. Cycle 1 is CLEAR and cycle 26 is DONE.
  function automatic logic [19:0] job(input int k);
    if (k == 1)
      return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    else if (k >= 2 && k <= 5)
      return mk(1'b0, 1'b1, 1'b0, 1'b0, 2'(5 - k), 5'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    else if (k >= 6 && k <= 12)
      return mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 5'(k - 6), arv_tab[k - 6], 1'b0, 2'd0, 1'b1, 1'b0);
    else if (k >= 13 && k <= 21)
      return mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    else if (k >= 22 && k <= 25)
      return mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 5'd0, 4'd0, 1'b1, 2'(k - 22), 1'b1, 1'b0);
    else if (k == 26)
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    else
      return ZERO;
  endfunction

  task automatic step(input logic s, input logic a, input logic [19:0] e);
    @(posedge Clock);
    #1;
    exp_q.push_back(e);
    start = s;
    abort = a;
  endtask

  task automatic check_perf(input string name, input logic [31:0] eb, input logic [15:0] ej);
    checks++;
    if (perf_busy_cycles !== eb || perf_jobs !== ej) begin
      errors++;
      $display("FAIL %s: actual busy_cycles=%0d jobs=%0d, required busy_cycles=%0d jobs=%0d",
               name, perf_busy_cycles, perf_jobs, eb, ej);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, away from the rising edge
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      e = exp_q.pop_front();
      checks++;
      if (got_s !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: actual %05h required %05h", $time, got_s, e);
      end
    end
  end

  initial begin
    arv_tab[0] = 4'b0001; arv_tab[1] = 4'b0011; arv_tab[2] = 4'b0111; arv_tab[3] = 4'b1111;
    arv_tab[4] = 4'b1110; arv_tab[5] = 4'b1100; arv_tab[6] = 4'b1000;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;

    step(1'b0, 1'b0, ZERO);
    check_perf("perf_in_reset", 32'd0, 16'd0);
    step(1'b0, 1'b0, ZERO);
    rst_n = 1'b1;
    step(1'b0, 1'b0, ZERO);

    // Job 1: start and abort arrive together in IDLE, and a start pulse in mid-job must be ignored.
    step(1'b1, 1'b1, ZERO);
    for (int k = 1; k <= 26; k++) step(k == 10, 1'b0, job(k));
    repeat (3) step(1'b0, 1'b0, ZERO);

    // Job 2: abort while STREAM has cnt=2 (job cycle 8). ABORT follows, then IDLE, with no done pulse.
    step(1'b1, 1'b0, ZERO);
    for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, job(k));
    step(1'b0, 1'b1, job(8));
    step(1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0));
    repeat (3) step(1'b0, 1'b0, ZERO);

    // Job 3: asynchronous reset in the middle of DRAIN (job cycle 15)
    step(1'b1, 1'b0, ZERO);
    for (int k = 1; k <= 14; k++) step(1'b0, 1'b0, job(k));
    @(posedge Clock);
    #1;
    exp_q.push_back(ZERO);
    #1;
    rst_n = 1'b0;
    #1;
    check_perf("perf_async_reset", 32'd0, 16'd0);
    step(1'b0, 1'b0, ZERO);
    step(1'b0, 1'b0, ZERO);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, ZERO);

    // Jobs 4 and 5: start is held high, so the second job begins one IDLE cycle after DONE.
    step(1'b1, 1'b0, ZERO);
    for (int k = 1; k <= 26; k++) step(1'b1, 1'b0, job(k));
    step(1'b1, 1'b0, ZERO);
    for (int k = 1; k <= 26; k++) step(1'b0, 1'b0, job(k));
    step(1'b0, 1'b0, ZERO);
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_CNT_EN
    check_perf("perf_two_jobs", 32'd50, 16'd2);
`else
    check_perf("perf_two_jobs", 32'd0, 16'd0);
`endif
    repeat (2) step(1'b0, 1'b0, ZERO);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl.md
SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter STREAM_LEN, default 7, giving the A-stream cycle count (4 vectors + 3 skew); legal range 4..31.
REQ-002 SHALL have parameter DRAIN_LEN, default 13, giving the flush cycle count after streaming; legal range 4..31.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, job request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, cancels the current job.
REQ-007 SHALL have ports data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom, each output, 1, driving the PE-array control inputs of the same names.
REQ-008 SHALL have port b_row_idx, output, 2, the B row to present on b_top_in during LOAD_B.
REQ-009 SHALL have port a_step, output, 5, the stream-cycle index during STREAM.
REQ-010 SHALL have port a_row_valid, output, 4, where bit r means row r of the A input carries a real element this cycle; when the bit is 0, the external mux drives zero.
REQ-011 SHALL have port ps_capture, output, 1, strobe telling the result sink to latch ps_bottom_out.
REQ-012 SHALL have port ps_idx, output, 2, the result row index qualified by ps_capture.
REQ-013 SHALL have ports busy and done, each output, 1: job in progress, and a 1-cycle completion pulse.
REQ-014 SHALL have ports perf_busy_cycles, output, 32, and perf_jobs, output, 16 (see Configuration).

Function
REQ-015 SHALL be a Moore FSM with states IDLE, CLEAR, LOAD_B, STREAM, DRAIN, DONE and ABORT, all outputs decoded from registered state plus a 5-bit phase counter cnt.
REQ-016 In IDLE, start=1 at an edge SHALL move the FSM to CLEAR; start is ignored in all other states.
REQ-017 CLEAR SHALL last 1 cycle, assert data_clear=1 and all enables=0, and then go to LOAD_B with cnt=0.
REQ-018 LOAD_B SHALL last 4 cycles with en_b_shift_bottom=1 and b_row_idx=3-cnt (row 3 first), then go to STREAM with cnt=0.
REQ-019 STREAM SHALL last STREAM_LEN cycles with en_shift_right=1, en_shift_bottom=1 and a_step=cnt; a_row_valid[r]=1 iff 0 <= cnt-r <= 3.
REQ-020 DRAIN SHALL last DRAIN_LEN cycles with en_shift_right=1, en_shift_bottom=1, a_row_valid=0, and a_step=0.
REQ-021 In DRAIN, ps_capture SHALL be 1 in the last 4 cycles, with ps_idx = 0,1,2,3 in order.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in CLEAR, LOAD_B, STREAM, DRAIN and ABORT, and 0 in IDLE and DONE.
REQ-024 Outside the states named above, every enable, data_clear, ps_capture and a_row_valid SHALL be 0, and b_row_idx and ps_idx SHALL be 0.
REQ-025 abort=1 in any busy state SHALL win over all progress and move the FSM to ABORT; abort is ignored in IDLE and DONE.
REQ-026 ABORT SHALL last 1 cycle with data_clear=1 and all enables=0, then go to IDLE with no done pulse.
REQ-027 When start and abort are both 1 in IDLE, start SHALL be taken; abort has no effect there.
REQ-028 cnt SHALL reset to 0 on every state change and never wrap within a state.
REQ-029 With the default parameters, a job SHALL take 26 cycles from the first CLEAR cycle to DONE inclusive.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and cnt=0, with all outputs 0 (including the perf counters) and no dependence on Clock.
REQ-031 Reset asserted mid-job SHALL abandon the job with no done pulse; the FSM restarts only on a new start after release.

Configuration
REQ-032 With macro SYSTOLIC_ARRAY_CTRL_PERF_CNT_EN defined, perf_busy_cycles SHALL increment each cycle busy=1 (saturating at all-ones), and perf_jobs SHALL increment on each done pulse (wrapping).
REQ-033 Without SYSTOLIC_ARRAY_CTRL_PERF_CNT_EN, both perf ports SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-034 Reset released, start pulse at edge 0 -> CLEAR in cycle 1, LOAD_B cycles 2-5 (b_row_idx 3,2,1,0), STREAM 6-12, DRAIN 13-25 (ps_capture 22-25, ps_idx 0-3), done=1 in cycle 26 only.
REQ-035 STREAM cnt=0 -> a_row_valid=0001; cnt=3 -> 1111; cnt=5 -> 1100; cnt=6 -> 1000.
REQ-036 abort=1 during STREAM cnt=2 -> next cycle ABORT with data_clear=1, then IDLE; done never rises; busy falls after ABORT.
REQ-037 start held high through a full job -> a second job begins at the edge after DONE returns to IDLE; start pulses during busy are not queued.
REQ-038 rst_n=0 asynchronously in DRAIN -> all outputs 0 before the next Clock edge; FSM in IDLE after release.
REQ-039 With PERF_CNT_EN defined, two back-to-back default jobs -> perf_jobs=2 and perf_busy_cycles=50; without the macro, both ports read 0.
